res_arbiter: RTL and testbench
==============================

RES_ARBITER -- requirements
Module: res_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing the resource (legal range 2..8).
REQ-002 Parameter: LEN_W, default 4, width of the per-requester burst length field.
REQ-003 Port: clk  input  1  single clock; all logic is rising-edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  NUM_REQ  per-requester request, level.
REQ-006 Port: req_len  input  NUM_REQ*LEN_W  burst length minus 1; requester i occupies bits [i*LEN_W +: LEN_W].
REQ-007 Port: gnt  output  NUM_REQ  one-hot grant, registered.
REQ-008 Port: gnt_id  output  $clog2(NUM_REQ)  binary index of the granted requester; valid while busy=1.
REQ-009 Port: busy  output  1  resource is owned.
REQ-010 Port: beat_ready  input  1  resource accepts one beat this cycle.
REQ-011 Port: beat_last  output  1  current beat is the final beat of the burst (busy & count==0).
REQ-012 Port: done  output  1  one-cycle pulse, registered, on the cycle after the final beat is accepted.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and OWN.
REQ-014 In IDLE with req != 0, the block SHALL pick the winner by round-robin: search starts at (last_id+1) mod NUM_REQ, wraps, and the first set req bit wins.
REQ-015 On the rising edge that samples the winning req in IDLE, the block SHALL assert gnt/gnt_id/busy, load count <= req_len of the winner, set last_id <= winner, and enter OWN (1-cycle latency from req to gnt).
REQ-016 In OWN, each cycle with beat_ready=1 SHALL decrement count; beat_ready=0 SHALL hold count and the grant.
REQ-017 In OWN with count==0 and beat_ready=1, the next edge SHALL clear gnt and busy, return to IDLE, and assert done for one cycle.
REQ-018 A burst SHALL be req_len+1 beats; req_len=0 gives a single beat; req_len=2^LEN_W-1 SHALL give 2^LEN_W beats without counter wrap.
REQ-019 req and req_len SHALL be ignored during OWN; deasserting req mid-burst SHALL NOT shorten or abort the burst.
REQ-020 The cycle in which done=1 SHALL be an IDLE cycle that arbitrates, so back-to-back bursts have exactly one idle (gnt=0) cycle between them.
REQ-021 last_id SHALL update only on grant; idle cycles SHALL NOT move the round-robin pointer.
REQ-022 A requester with req held continuously SHALL be granted within NUM_REQ-1 intervening bursts (no starvation).
REQ-023 At most one gnt bit SHALL be set in any cycle; gnt SHALL equal one-hot(gnt_id) whenever busy=1 and SHALL be 0 when busy=0.

Reset
REQ-024 With rst=1 at an edge: state=IDLE, gnt=0, gnt_id=0, busy=0, done=0, count=0, last_id=NUM_REQ-1 (so requester 0 has first priority).
REQ-025 rst asserted during OWN SHALL abort the burst at that edge with no done pulse; rst SHALL take priority over every other event in the same cycle.
REQ-026 beat_last SHALL be 0 while rst=1 and on the cycle following reset.

Verification
REQ-027 After reset, req=4'b1111, all req_len=0, beat_ready=1 -> grants in order 0,1,2,3,0, each gnt 1 cycle high followed by 1 idle cycle; done follows each.
REQ-028 req=4'b0100, req_len[2]=3, beat_ready toggled 1,0,1,0,... -> gnt=4'b0100 held for 7 cycles; beat_last on the 4th accepted beat; done 1 cycle later.
REQ-029 req[1] granted with req_len=5, req[1] dropped after 2 beats, req[3] raised mid-burst -> burst runs to 6 beats, then next grant is 3.
REQ-030 req_len=4'hF, beat_ready=1 -> exactly 16 beats, single done, count never wraps.
REQ-031 rst pulsed on the 3rd beat of a burst -> gnt=0, busy=0 next cycle, no done; with req=4'b1111 the next grant goes to requester 0.
REQ-032 Random req/req_len/beat_ready, 10k cycles -> assertions hold: gnt one-hot-or-zero, gnt==onehot(gnt_id) when busy, beats per burst == req_len+1, every held request granted within NUM_REQ-1 bursts.

Source files
------------

// File: rtl/res_arbiter.sv
// Round-robin arbiter granting a shared resource to one of NUM_REQ requesters for a burst of req_len+1 beats.
// Latency: one cycle from req to gnt; done is a pulse on the cycle after the final beat is accepted.
// Backpressure: beat_ready=0 holds the burst count and the grant; req and req_len are ignored while a burst is owned.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req, req_len      per-requester request level and burst length minus 1 (LEN_W bits per requester)
//   gnt, gnt_id, busy registered one-hot grant, its binary index, resource-owned flag
//   beat_ready        resource accepts one beat this cycle
//   beat_last         current beat is the final one of the burst
//   done              one-cycle pulse after the final beat is accepted
module res_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    input  logic                       beat_ready,
    output logic                       beat_last,
    output logic                       done
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]         state_q,   state_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [ID_W-1:0]    gnt_id_q,  gnt_id_d;
    logic [LEN_W-1:0]   count_q,   count_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic               done_q,    done_d;

    logic [ID_W-1:0]    winner;
    logic               winner_found;
    logic [ID_W-1:0]    cand;
    logic [LEN_W-1:0]   winner_len;

    // Round-robin pick: scan from the requester after the last winner, wrapping,
    // so the last winner itself is considered last.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_id_q) + k) % NUM_REQ);
            if (!winner_found && req[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    assign winner_len = req_len[winner*LEN_W +: LEN_W];

    // count holds beats remaining minus 1, so the burst ends when a beat is
    // accepted at count==0; a full-scale length never needs to wrap.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        count_d   = count_q;
        last_id_d = last_id_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d         = OWN;
                    gnt_d           = '0;
                    gnt_d[winner]   = 1'b1;
                    gnt_id_d        = winner;
                    count_d         = winner_len;
                    last_id_d       = winner;
                end
            end
            default: begin
                if (beat_ready) begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            count_q   <= '0;
            last_id_q <= ID_W'(NUM_REQ - 1);
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            count_q   <= count_d;
            last_id_q <= last_id_d;
            done_q    <= done_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == OWN);
    assign done   = done_q;
    // Masked by rst so a burst being aborted never advertises a final beat.
    assign beat_last = busy & (count_q == '0) & ~rst;

endmodule

// File: tb/tb_res_arbiter.sv
module tb_res_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*LW-1:0] req_len;
    logic          beat_ready;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          busy;
    logic          beat_last;
    logic          done;

    res_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .beat_ready (beat_ready),
        .beat_last  (beat_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = free), beats still to transfer,
    // last winner, expected done pulse, and per-requester wait counters.
    int m_owner = -1;
    int m_left  = 0;
    int m_last  = N - 1;
    bit m_done  = 1'b0;
    int waited[N];

    // Observation counters used by the directed sequences.
    int beats = 0;
    int dones = 0;
    int gnt_cycles = 0;
    logic [N-1:0] gnt_watch = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*LW-1:0] ln, input logic rdy);
        logic [N-1:0] e_gnt;
        int w;
        rst = r; req = rq; req_len = ln; beat_ready = rdy;
        #1;
        chk("beat_last", {31'b0, beat_last}, {31'b0, (!r && m_owner >= 0 && m_left == 1)});
        if (busy && rdy && !r) beats++;
        @(posedge clk);
        if (r) begin
            m_owner = -1; m_left = 0; m_last = N - 1; m_done = 1'b0;
            for (int i = 0; i < N; i++) waited[i] = 0;
        end else if (m_owner < 0) begin
            m_done = 1'b0;
            if (rq != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && rq[(m_last + k) % N]) w = (m_last + k) % N;
                for (int i = 0; i < N; i++) begin
                    if (i == w) waited[i] = 0;
                    else if (rq[i]) begin
                        waited[i]++;
                        chk("starve_bound", {31'b0, (waited[i] <= N - 1)}, 32'd1);
                    end
                end
                m_owner = w;
                m_left  = int'(ln[w*LW +: LW]) + 1;
                m_last  = w;
            end
        end else begin
            m_done = 1'b0;
            if (rdy) begin
                m_left--;
                if (m_left == 0) begin
                    m_owner = -1;
                    m_done  = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) if (!rq[i] || r) waited[i] = 0;
        #1;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        chk("gnt",  {28'b0, gnt},  {28'b0, e_gnt});
        chk("busy", {31'b0, busy}, {31'b0, (m_owner >= 0)});
        chk("done", {31'b0, done}, {31'b0, m_done});
        if (m_owner >= 0) chk("gnt_id", {30'b0, gnt_id}, m_owner);
        if (done) dones++;
        if (gnt_watch != '0 && gnt == gnt_watch) gnt_cycles++;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       rdy;
        logic [3:0] e_gnt;
        logic       e_busy;
        logic       e_done;
        logic       e_bl;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst = 1'b1; req = '0; req_len = '0; beat_ready = 1'b0;

        // Back-to-back single-beat bursts rotate 0,1,2,3,0 with one idle cycle each.
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].rq, '0, tbl[i].rdy);
            chk("tbl_gnt",  {28'b0, gnt},       {28'b0, tbl[i].e_gnt});
            chk("tbl_busy", {31'b0, busy},      {31'b0, tbl[i].e_busy});
            chk("tbl_done", {31'b0, done},      {31'b0, tbl[i].e_done});
            chk("tbl_bl",   {31'b0, beat_last}, {31'b0, tbl[i].e_bl});
        end

        // Four-beat burst with beat_ready toggling: grant held 7 cycles.
        step(1'b1, '0, '0, 1'b0);
        beats = 0; dones = 0; gnt_cycles = 0; gnt_watch = 4'b0100;
        step(1'b0, 4'b0100, 16'h0300, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 16'h0300, (i % 2) == 0);
        chk("toggle_gnt_cycles", gnt_cycles, 32'd7);
        chk("toggle_beats", beats, 32'd4);
        chk("toggle_dones", dones, 32'd1);
        gnt_watch = '0;

        // Dropping req mid-burst does not shorten it; next grant goes to 3.
        step(1'b1, '0, '0, 1'b0);
        beats = 0; dones = 0;
        step(1'b0, 4'b0010, 16'h0050, 1'b1);
        step(1'b0, 4'b0010, 16'h0050, 1'b1);
        step(1'b0, 4'b0010, 16'h0050, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1000, 16'h0050, 1'b1);
        chk("drop_beats", beats, 32'd6);
        chk("drop_dones", dones, 32'd1);
        step(1'b0, 4'b1000, 16'h0050, 1'b1);
        chk("drop_next_id", {30'b0, gnt_id}, 32'd3);

        // Maximum length: 16 beats, one done.
        step(1'b1, '0, '0, 1'b0);
        beats = 0; dones = 0;
        step(1'b0, 4'b0001, 16'h000F, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 16'h000F, 1'b1);
        chk("max_beats", beats, 32'd16);
        chk("max_dones", dones, 32'd1);

        // Reset on the third beat aborts without done; requester 0 wins next.
        step(1'b1, '0, '0, 1'b0);
        dones = 0;
        step(1'b0, 4'b0010, 16'h0050, 1'b1);
        step(1'b0, '0, 16'h0050, 1'b1);
        step(1'b0, '0, 16'h0050, 1'b1);
        step(1'b1, 4'b1111, 16'h0050, 1'b1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_dones", dones, 32'd0);
        step(1'b0, 4'b1111, '0, 1'b1);
        chk("abort_next_gnt", {28'b0, gnt}, 32'h1);

        // beat_last masked while rst is high on a final beat.
        step(1'b1, '0, '0, 1'b0);
        step(1'b0, 4'b0001, '0, 1'b1);
        rst = 1'b1; #1;
        chk("bl_under_rst", {31'b0, beat_last}, 32'd0);
        step(1'b1, '0, '0, 1'b1);

        // Random traffic against the model.
        step(1'b1, '0, '0, 1'b0);
        begin
            logic [N-1:0] rq;
            rq = '0;
            for (int c = 0; c < 10000; c++) begin
                if ($urandom_range(0, 7) == 0) rq[$urandom_range(0, N-1)] ^= 1'b1;
                step(($urandom_range(0, 499) == 0), rq, N*LW'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
